// File: rtl/hazard_idex_stage.sv
// ID-stage hazard detection (load-use, ID-resolved branch dependences, HLT drain)
// and the ID/EX pipeline register feeding the forwarding unit.
module hazard_idex_stage #(
  parameter int DATA_W     = 16,
  parameter int REG_W      = 4,
  parameter int HALT_DRAIN = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [3:0]        id_opcode,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc_next,
  input  logic              branch_taken,
  input  logic              ex_mem_valid,
  input  logic [3:0]        ex_mem_opcode,
  input  logic [REG_W-1:0]  ex_mem_rd,
  output logic              stall,
  output logic              flush_ifid,
  output logic              id_ex_valid,
  output logic [3:0]        id_ex_opcode,
  output logic [REG_W-1:0]  id_ex_rs,
  output logic [REG_W-1:0]  id_ex_rt,
  output logic [REG_W-1:0]  id_ex_rd,
  output logic [DATA_W-1:0] id_ex_rs_data,
  output logic [DATA_W-1:0] id_ex_rt_data,
  output logic [DATA_W-1:0] id_ex_imm,
  output logic [DATA_W-1:0] id_ex_pc_next,
  output logic              halted
);

  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;
  localparam int CNT_W = (HALT_DRAIN < 2) ? 1 : $clog2(HALT_DRAIN + 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  function automatic logic uses_rs(input logic [3:0] op);
    return (op <= 4'b1011) || (op == OP_BR);
  endfunction

  function automatic logic uses_rt(input logic [3:0] op);
    return (op <= 4'b0011) || (op == 4'b0111) || (op == 4'b1001);
  endfunction

  function automatic logic is_writer(input logic [3:0] op);
    return (op <= 4'b1000) || (op == 4'b1010) || (op == 4'b1011) || (op == 4'b1110);
  endfunction

  function automatic logic sets_flags(input logic [3:0] op);
    return (op <= 4'b0010) || ((op >= 4'b0100) && (op <= 4'b0110));
  endfunction

  logic load_use, br_reg, br_flag, id_is_br, capture_hlt;

  always_comb begin
    id_is_br = (id_opcode == OP_BR);
    load_use = id_valid && id_ex_valid && (id_ex_opcode == OP_LW) && (id_ex_rd != '0) &&
               ((uses_rs(id_opcode) && (id_ex_rd == id_rs)) ||
                (uses_rt(id_opcode) && (id_ex_rd == id_rt)));
    // A BR reads its target in ID, so any in-flight producer of rs must land first.
    br_reg   = id_valid && id_is_br && (id_rs != '0) &&
               ((id_ex_valid && is_writer(id_ex_opcode) && (id_ex_rd != '0) && (id_ex_rd == id_rs)) ||
                (ex_mem_valid && (ex_mem_opcode == OP_LW) && (ex_mem_rd == id_rs)));
    br_flag  = id_valid && (id_is_br || (id_opcode == OP_B)) &&
               id_ex_valid && sets_flags(id_ex_opcode);
    stall       = load_use || br_reg || br_flag || (state_reg != RUN);
    flush_ifid  = branch_taken && id_valid && !stall && (state_reg == RUN);
    capture_hlt = id_valid && !stall && (id_opcode == OP_HLT);
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      RUN: begin
        if (capture_hlt) begin
          state_next = DRAIN;
          cnt_next   = CNT_W'(HALT_DRAIN);
        end
      end
      DRAIN: begin
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) state_next = HALTED;
      end
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // A bubble zeroes rd as well, so it can never produce a forwarding match.
  always_ff @(posedge clk) begin
    if (!rst_n || stall) begin
      id_ex_valid   <= 1'b0;
      id_ex_opcode  <= '0;
      id_ex_rs      <= '0;
      id_ex_rt      <= '0;
      id_ex_rd      <= '0;
      id_ex_rs_data <= '0;
      id_ex_rt_data <= '0;
      id_ex_imm     <= '0;
      id_ex_pc_next <= '0;
    end else begin
      id_ex_valid   <= id_valid;
      id_ex_opcode  <= id_opcode;
      id_ex_rs      <= id_rs;
      id_ex_rt      <= id_rt;
      id_ex_rd      <= id_rd;
      id_ex_rs_data <= id_rs_data;
      id_ex_rt_data <= id_rt_data;
      id_ex_imm     <= id_imm;
      id_ex_pc_next <= id_pc_next;
    end
  end

  assign halted = (state_reg == HALTED);

endmodule

// File: tb/tb_hazard_idex_stage.sv
// Directed bench for hazard_idex_stage: load-use, BR register/load/flag stalls,
// taken-branch flush and the HLT drain / reset sequence.
module tb_hazard_idex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [3:0]  id_opcode;
  logic [3:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_rs_data, id_rt_data, id_imm, id_pc_next;
  logic        branch_taken;
  logic        ex_mem_valid;
  logic [3:0]  ex_mem_opcode;
  logic [3:0]  ex_mem_rd;
  logic        stall, flush_ifid, id_ex_valid, halted;
  logic [3:0]  id_ex_opcode, id_ex_rs, id_ex_rt, id_ex_rd;
  logic [15:0] id_ex_rs_data, id_ex_rt_data, id_ex_imm, id_ex_pc_next;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_idex_stage #(.DATA_W(16), .REG_W(4), .HALT_DRAIN(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_pc_next(id_pc_next),
    .branch_taken(branch_taken),
    .ex_mem_valid(ex_mem_valid), .ex_mem_opcode(ex_mem_opcode), .ex_mem_rd(ex_mem_rd),
    .stall(stall), .flush_ifid(flush_ifid),
    .id_ex_valid(id_ex_valid), .id_ex_opcode(id_ex_opcode),
    .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
    .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data),
    .id_ex_imm(id_ex_imm), .id_ex_pc_next(id_ex_pc_next),
    .halted(halted)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-24s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present an instruction in ID; data fields are tagged with the register numbers.
  task automatic issue(input logic v, input logic [3:0] op, input logic [3:0] rs,
                       input logic [3:0] rt, input logic [3:0] rd);
    id_valid   = v;
    id_opcode  = op;
    id_rs      = rs;
    id_rt      = rt;
    id_rd      = rd;
    id_rs_data = 16'h1000 | {12'h0, rs};
    id_rt_data = 16'h2000 | {12'h0, rt};
    id_imm     = 16'h3000 | {12'h0, rd};
    id_pc_next = 16'h4000 | {8'h0, op, rd};
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    branch_taken = 1'b0;
    ex_mem_valid = 1'b0; ex_mem_opcode = 4'h0; ex_mem_rd = 4'h0;
    issue(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    tick(); tick();
    chk("reset_valid", {15'h0, id_ex_valid}, 16'h0);
    chk("reset_halted", {15'h0, halted}, 16'h0);
    chk("reset_stall", {15'h0, stall}, 16'h0);
    rst_n = 1'b1;

    // Load-use: LW r3 then ADD r5,r3,r1
    issue(1'b1, 4'h8, 4'h1, 4'h0, 4'h3);
    chk("lw_no_stall", {15'h0, stall}, 16'h0);
    tick();
    chk("lw_in_idex_op", {12'h0, id_ex_opcode}, 16'h8);
    issue(1'b1, 4'h0, 4'h3, 4'h1, 4'h5);
    chk("lu_stall", {15'h0, stall}, 16'h1);
    tick();
    chk("lu_bubble_valid", {15'h0, id_ex_valid}, 16'h0);
    chk("lu_bubble_rd", {12'h0, id_ex_rd}, 16'h0);
    chk("lu_released", {15'h0, stall}, 16'h0);
    tick();
    chk("add_valid", {15'h0, id_ex_valid}, 16'h1);
    chk("add_rs", {12'h0, id_ex_rs}, 16'h3);
    chk("add_rs_data", id_ex_rs_data, 16'h1003);
    chk("add_rt_data", id_ex_rt_data, 16'h2001);
    chk("add_imm", id_ex_imm, 16'h3005);

    // Zero-destination LW and SW rd field do not cause load-use
    issue(1'b1, 4'h8, 4'h1, 4'h0, 4'h0);
    tick();
    issue(1'b1, 4'h0, 4'h0, 4'h0, 4'h5);
    chk("lw_r0_no_stall", {15'h0, stall}, 16'h0);
    tick();
    issue(1'b1, 4'h9, 4'h2, 4'h3, 4'h3);
    tick();
    chk("sw_captured", {12'h0, id_ex_opcode}, 16'h9);
    issue(1'b1, 4'h0, 4'h3, 4'h3, 4'h6);
    chk("sw_no_stall", {15'h0, stall}, 16'h0);
    tick();

    // BR on a non-flag writer (PADDSB r4), branch taken held high
    issue(1'b1, 4'h7, 4'h1, 4'h2, 4'h4);
    tick();
    ex_mem_valid = 1'b1; ex_mem_opcode = 4'h0; ex_mem_rd = 4'h6;
    branch_taken = 1'b1;
    issue(1'b1, 4'hD, 4'h4, 4'h0, 4'h0);
    chk("br_reg_stall", {15'h0, stall}, 16'h1);
    chk("br_reg_noflush", {15'h0, flush_ifid}, 16'h0);
    tick();
    chk("br_reg_bubble", {15'h0, id_ex_valid}, 16'h0);
    ex_mem_opcode = 4'h7; ex_mem_rd = 4'h4;
    #1;
    chk("br_reg_released", {15'h0, stall}, 16'h0);
    chk("br_reg_flush", {15'h0, flush_ifid}, 16'h1);
    tick();
    chk("br_captured_op", {12'h0, id_ex_opcode}, 16'hD);
    chk("br_captured_valid", {15'h0, id_ex_valid}, 16'h1);
    branch_taken = 1'b0;
    ex_mem_valid = 1'b0;

    // BR on a load: two stall cycles
    issue(1'b1, 4'h8, 4'h1, 4'h0, 4'h4);
    chk("lw4_no_stall", {15'h0, stall}, 16'h0);
    tick();
    issue(1'b1, 4'hD, 4'h4, 4'h0, 4'h0);
    chk("br_lw_stall1", {15'h0, stall}, 16'h1);
    tick();
    ex_mem_valid = 1'b1; ex_mem_opcode = 4'h8; ex_mem_rd = 4'h4;
    #1;
    chk("br_lw_stall2", {15'h0, stall}, 16'h1);
    tick();
    chk("br_lw_bubble2", {15'h0, id_ex_valid}, 16'h0);
    ex_mem_valid = 1'b0;
    #1;
    chk("br_lw_released", {15'h0, stall}, 16'h0);
    tick();
    chk("br_lw_captured", {12'h0, id_ex_opcode}, 16'hD);

    // B after SUB: flag dependence stalls, then flush
    issue(1'b1, 4'h1, 4'h1, 4'h2, 4'h7);
    tick();
    branch_taken = 1'b1;
    issue(1'b1, 4'hC, 4'h0, 4'h0, 4'h0);
    chk("b_flag_stall", {15'h0, stall}, 16'h1);
    chk("b_flag_noflush", {15'h0, flush_ifid}, 16'h0);
    tick();
    chk("b_flag_flush", {15'h0, flush_ifid}, 16'h1);
    tick();
    chk("b_captured_op", {12'h0, id_ex_opcode}, 16'hC);
    chk("b_captured_valid", {15'h0, id_ex_valid}, 16'h1);
    chk("b_pc_next", id_ex_pc_next, 16'h40C0);

    // HLT drain, sticky halt, then reset
    issue(1'b1, 4'hF, 4'h0, 4'h0, 4'h0);
    chk("hlt_no_stall", {15'h0, stall}, 16'h0);
    tick();  // edge N
    chk("hlt_captured", {12'h0, id_ex_opcode}, 16'hF);
    chk("hlt_halted_n", {15'h0, halted}, 16'h0);
    issue(1'b1, 4'h0, 4'h1, 4'h2, 4'h3);
    chk("drain_stall", {15'h0, stall}, 16'h1);
    chk("drain_noflush", {15'h0, flush_ifid}, 16'h0);
    tick();  // N+1
    chk("drain1_bubble", {15'h0, id_ex_valid}, 16'h0);
    chk("drain1_halted", {15'h0, halted}, 16'h0);
    tick();  // N+2
    chk("drain2_halted", {15'h0, halted}, 16'h0);
    tick();  // N+3
    chk("n3_halted", {15'h0, halted}, 16'h1);
    chk("n3_bubble", {15'h0, id_ex_valid}, 16'h0);
    tick();  // N+4
    chk("n4_sticky", {15'h0, halted}, 16'h1);
    chk("n4_stall", {15'h0, stall}, 16'h1);
    branch_taken = 1'b0;
    rst_n = 1'b0;
    tick();  // N+5
    chk("rst_halted", {15'h0, halted}, 16'h0);
    chk("rst_valid", {15'h0, id_ex_valid}, 16'h0);
    rst_n = 1'b1;
    issue(1'b1, 4'h0, 4'h1, 4'h2, 4'h2);
    chk("post_rst_stall", {15'h0, stall}, 16'h0);
    tick();
    chk("post_rst_valid", {15'h0, id_ex_valid}, 16'h1);
    chk("post_rst_rd", {12'h0, id_ex_rd}, 16'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
